// File: rtl/fpmul_operand_stage_if.sv
// rtl/fpmul_operand_stage_if.sv - operand handshake and unpacked-field bundle for fpmul_operand_stage
interface fpmul_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        as;
  logic        bs;
  logic [10:0] ae;
  logic [10:0] be;
  logic [51:0] am;
  logic [51:0] bm;
  logic        en;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  spec_class;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, as, bs, ae, be, am, bm, en, out_valid, spec_class
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, as, bs, ae, be, am, bm, en, out_valid, spec_class
  );
endinterface

// File: rtl/fpmul_operand_stage.sv
// rtl/fpmul_operand_stage.sv - binary64 unpack/classify stage with multicycle hold before the multiplier capture
// Optional FTZ_EN: flush subnormal operands to zero before classification.
module fpmul_operand_stage #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fpmul_operand_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, CAP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept;

  logic        a_s, b_s;
  logic [10:0] a_e, b_e;
  logic [51:0] a_m, b_m;
  logic        a_zero, a_sub, a_inf, a_nan;
  logic        b_zero, b_sub, b_inf, b_nan;
  logic [2:0]  cls;

  logic        as_q, bs_q, en_q, out_valid_q;
  logic [10:0] ae_q, be_q;
  logic [51:0] am_q, bm_q;
  logic [2:0]  cls_q;

  always_comb begin
    a_s = bus.in_a[63];
    a_e = bus.in_a[62:52];
    a_m = bus.in_a[51:0];
    b_s = bus.in_b[63];
    b_e = bus.in_b[62:52];
    b_m = bus.in_b[51:0];
    a_sub = (a_e == 11'd0) && (a_m != 52'd0);
    b_sub = (b_e == 11'd0) && (b_m != 52'd0);
`ifdef FTZ_EN
    // Flushed operand keeps its sign; its fields then classify as zero.
    if (a_sub) begin
      a_m   = 52'd0;
      a_sub = 1'b0;
    end
    if (b_sub) begin
      b_m   = 52'd0;
      b_sub = 1'b0;
    end
`endif
    a_zero = (a_e == 11'd0)    && (a_m == 52'd0);
    b_zero = (b_e == 11'd0)    && (b_m == 52'd0);
    a_inf  = (a_e == 11'h7ff)  && (a_m == 52'd0);
    b_inf  = (b_e == 11'h7ff)  && (b_m == 52'd0);
    a_nan  = (a_e == 11'h7ff)  && (a_m != 52'd0);
    b_nan  = (b_e == 11'h7ff)  && (b_m != 52'd0);

    if (a_nan || b_nan)                          cls = 3'd3;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) cls = 3'd4;
    else if (a_inf || b_inf)                     cls = 3'd2;
    else if (a_zero || b_zero)                   cls = 3'd1;
    else if (a_sub || b_sub)                     cls = 3'd5;
    else                                         cls = 3'd0;
  end

  assign accept = (state == IDLE) && bus.in_valid;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (cls == 3'd0) begin
            state_nx = HOLD;
            cnt_nx   = 4'(HOLD_CYCLES - 1);
          end else begin
            state_nx = CAP;
          end
        end
      end
      HOLD: begin
        if (cnt == 4'd0) state_nx = CAP;
        else             cnt_nx   = cnt - 4'd1;
      end
      CAP: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // en/out_valid are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      as_q        <= 1'b0;
      bs_q        <= 1'b0;
      ae_q        <= 11'd0;
      be_q        <= 11'd0;
      am_q        <= 52'd0;
      bm_q        <= 52'd0;
      cls_q       <= 3'd0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      en_q        <= (state_nx != IDLE);
      out_valid_q <= (state_nx == CAP);
      if (accept) begin
        as_q  <= a_s;
        bs_q  <= b_s;
        ae_q  <= a_e;
        be_q  <= b_e;
        am_q  <= a_m;
        bm_q  <= b_m;
        cls_q <= cls;
      end
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.as         = as_q;
  assign bus.bs         = bs_q;
  assign bus.ae         = ae_q;
  assign bus.be         = be_q;
  assign bus.am         = am_q;
  assign bus.bm         = bm_q;
  assign bus.en         = en_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.spec_class = cls_q;

endmodule
